pid_gen: RTL and testbench
==========================

# pid_gen

Parametrised next-generation PID controller for the eBike motor drive path. It samples a signed torque/cadence error once per decimation tick and computes P, I and D terms from runtime-programmable gains. Each sum is computed in a registered pipeline and saturated to an unsigned drive magnitude, which is held between updates and flagged with a one-cycle valid pulse. It sits between the sensor-conditioning block that produces `error` and the PWM/commutation stage that consumes `drv_mag`.

## Interface
- ERR_W, 13: signed error width
- OUT_W, 12: unsigned drive magnitude width
- INT_W, 18: integrator width; must satisfy INT_W-1 >= OUT_W
- DECIM_W, 20: decimator width; tick period 2^DECIM_W cycles (bench uses 4)
- D_DEPTH, 3: derivative history depth in ticks (>=1)
- SLEW_MAX, 64: max drv_mag change per update (only with PID_SLEW_EN)
- clk  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- error  in  ERR_W  signed error, sampled on tick
- clr_int  in  1  synchronous integrator clear (eBike: not_pedaling)
- kp  in  4  unsigned proportional gain, sampled on tick
- kd  in  4  unsigned derivative gain, sampled on tick
- ki_shift  in  3  integral right-shift, sampled on tick
- drv_mag  out  OUT_W  saturated drive magnitude, held between updates
- drv_vld  out  1  one-cycle pulse when drv_mag updates
- sat  out  1  last sum was clamped (registered with drv_mag)

## Operation
- Decimator increments every cycle and wraps. `tick` is asserted in the cycle where the decimator is all ones.
- Stage 0 (tick cycle T), registered at the end of T:
  - P = error * kp (signed).
  - D: diff = error - hist[D_DEPTH-1]. diff is clamped to [-256, 255], then multiplied by kd.
  - hist shifts: hist[0] <= error, hist[i] <= hist[i-1].
  - ki_shift is captured.
- Integrator: on tick, acc = integrator + sign-extended error.
  - acc is clamped to [0, 2^(INT_W-1)-1]; the integrator never goes negative.
  - clr_int forces integrator to 0 on any cycle. On a tick, clr_int wins; P, D and history still update.
- I = integrator[INT_W-2 -: OUT_W] >> captured ki_shift. It uses the post-update integrator.
- Stage 1 (end of T+1): sum = P + I + D, signed, SUM_W = max(ERR_W, OUT_W) + 6 bits. This width cannot overflow.
- Stage 2 (end of T+2):
  - sum < 0 → drv_mag = 0, sat = 1.
  - sum > 2^OUT_W - 1 → drv_mag = all ones, sat = 1.
  - Otherwise drv_mag = sum, sat = 0.
  - drv_vld = 1 for that single cycle.
- Between ticks, drv_mag and sat hold. Gain changes between ticks have no effect until the next tick.

## Timing
- Reset: decimator, hist, integrator, pipeline regs, drv_mag, drv_vld and sat are all 0, asynchronously.
  - First tick occurs 2^DECIM_W - 1 cycles after rst deasserts.
  - rst mid-pipeline discards in-flight results; no drv_vld is produced for them.
- Latency: drv_vld is high in cycle T+3, i.e. 3 cycles after the tick cycle.
- Throughput: one update per 2^DECIM_W cycles. The pipeline is always empty before the next tick (DECIM_W >= 2 required).
- clr_int asserted in T+1 or T+2 does not alter that update's I; it takes effect at the next tick.

## Configuration
- PID_SLEW_EN defined: the stage-2 output is additionally limited to drv_mag_prev ± SLEW_MAX, applied after saturation.
  - sat reflects range clamping only.
  - Reset still forces drv_mag to 0.
- Not defined: drv_mag equals the saturated sum directly. SLEW_MAX is ignored.

## Test plan
- Reset/first tick (DECIM_W=4): hold rst 5 cycles → all outputs 0; release → first drv_vld exactly 18 cycles later (tick at cycle 15, +3).
- P only (kp=1, kd=0, clr_int=1):
  - error=100 → drv_mag=100, sat=0.
  - error=-5 → drv_mag=0, sat=1.
  - kp=15, error=4095 → drv_mag=4095, sat=1.
- Integrator (kp=0, kd=0, ki_shift=0, error=32):
  - After 10 ticks → drv_mag=10.
  - error=4095 sustained → integrator clamps at 131071, drv_mag=4095.
  - error=-4096 sustained → integrator reaches 0, never wraps.
  - ki_shift=2 with integrator=32·40 → drv_mag=10.
- Derivative (kp=0, kd=2, clr_int=1, D_DEPTH=3):
  - error steps 0→300 at a tick → drv_mag=510.
  - The 4th tick after the step → drv_mag=0.
  - Step 300→0 → drv_mag=0, sat=1.
- clr_int coincident with tick (integrator=3200, kp=1, error=50) → integrator=0, drv_mag=50. rst asserted in T+1 → no drv_vld, drv_mag=0.
- With PID_SLEW_EN, SLEW_MAX=64, kp=1, error 0→1000 → successive drv_mag 64, 128, 192, …, 960, 1000.

Source files
------------

// File: rtl/pid_gen.sv
// pid_gen: decimated PID controller, signed error in, saturated unsigned drive magnitude out.
// Latency: drv_vld pulses 3 cycles after the decimator tick; one update per 2^DECIM_W cycles.
// Backpressure: none, the consumer must take every drv_vld pulse. Optional slew limiter: PID_SLEW_EN.
module pid_gen #(
    parameter int ERR_W    = 13,
    parameter int OUT_W    = 12,
    parameter int INT_W    = 18,
    parameter int DECIM_W  = 20,
    parameter int D_DEPTH  = 3,
    parameter int SLEW_MAX = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    clr_int,
    input  logic [3:0]              kp,
    input  logic [3:0]              kd,
    input  logic [2:0]              ki_shift,
    output logic [OUT_W-1:0]        drv_mag,
    output logic                    drv_vld,
    output logic                    sat
);
    localparam int SUM_W = ((ERR_W > OUT_W) ? ERR_W : OUT_W) + 6;
    localparam int P_W   = ERR_W + 5;
    localparam int DF_W  = ERR_W + 1;
    localparam int D_W   = 14;
    localparam logic signed [DF_W-1:0] DIFF_HI = DF_W'(255);
    localparam logic signed [DF_W-1:0] DIFF_LO = DF_W'(-256);
    localparam logic [INT_W-1:0]       INT_MAX = {1'b0, {(INT_W-1){1'b1}}};

    typedef struct packed {
        logic signed [P_W-1:0] p;
        logic signed [D_W-1:0] d;
        logic [2:0]            ks;
    } s0_t;

    logic [DECIM_W-1:0]      decim;
    logic                    tick;
    logic signed [ERR_W-1:0] hist [D_DEPTH];
    logic [INT_W-1:0]        integ;

    logic signed [DF_W-1:0]  diff;
    logic signed [8:0]       diff_c;
    logic signed [P_W-1:0]   p_nxt;
    logic signed [D_W-1:0]   d_nxt;
    logic signed [INT_W:0]   acc;
    logic [INT_W-1:0]        acc_c;

    s0_t                     s0_q;
    logic                    v0;
    logic [OUT_W-1:0]        i_term;
    logic signed [SUM_W-1:0] sum_nxt;
    logic signed [SUM_W-1:0] sum_q;
    logic                    v1;

    logic [OUT_W-1:0]        clip_mag;
    logic                    clip;
    logic [OUT_W-1:0]        mag_nxt;

    assign tick = &decim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            decim <= '0;
        end else begin
            decim <= decim + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
        end else if (tick) begin
            hist[0] <= error;
            for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    // Derivative is taken over D_DEPTH ticks and limited to 9 bits before the gain.
    always_comb begin
        diff = DF_W'(error) - DF_W'(hist[D_DEPTH-1]);
        if (diff > DIFF_HI) begin
            diff_c = DIFF_HI[8:0];
        end else if (diff < DIFF_LO) begin
            diff_c = DIFF_LO[8:0];
        end else begin
            diff_c = diff[8:0];
        end
        p_nxt = P_W'(error) * P_W'($signed({1'b0, kp}));
        d_nxt = D_W'(diff_c) * D_W'($signed({1'b0, kd}));
    end

    always_comb begin
        acc = $signed({1'b0, integ}) + (INT_W+1)'(error);
        if (acc[INT_W]) begin
            acc_c = '0;
        end else if (acc[INT_W-1]) begin
            acc_c = INT_MAX;
        end else begin
            acc_c = acc[INT_W-1:0];
        end
    end

    // clr_int has priority over the tick update so a stopped rider never winds up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ <= '0;
        end else if (clr_int) begin
            integ <= '0;
        end else if (tick) begin
            integ <= acc_c;
        end
    end

    // The integrator register already holds the tick's update during T+1.
    always_comb begin
        i_term  = integ[INT_W-2 -: OUT_W] >> s0_q.ks;
        sum_nxt = SUM_W'(s0_q.p) + SUM_W'(s0_q.d) + $signed(SUM_W'(i_term));
    end

    always_comb begin
        clip     = 1'b0;
        clip_mag = sum_q[OUT_W-1:0];
        if (sum_q[SUM_W-1]) begin
            clip     = 1'b1;
            clip_mag = '0;
        end else if (|sum_q[SUM_W-2:OUT_W]) begin
            clip     = 1'b1;
            clip_mag = '1;
        end
    end

`ifdef PID_SLEW_EN
    localparam logic [OUT_W:0] SLEW = (OUT_W+1)'(SLEW_MAX);

    always_comb begin
        mag_nxt = clip_mag;
        if ({1'b0, clip_mag} > {1'b0, drv_mag} + SLEW) begin
            mag_nxt = drv_mag + SLEW[OUT_W-1:0];
        end else if ({1'b0, drv_mag} > {1'b0, clip_mag} + SLEW) begin
            mag_nxt = drv_mag - SLEW[OUT_W-1:0];
        end
    end
`else
    assign mag_nxt = clip_mag;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q    <= '0;
            v0      <= 1'b0;
            sum_q   <= '0;
            v1      <= 1'b0;
            drv_mag <= '0;
            drv_vld <= 1'b0;
            sat     <= 1'b0;
        end else begin
            v0      <= tick;
            v1      <= v0;
            drv_vld <= v1;
            if (tick) begin
                s0_q <= '{p: p_nxt, d: d_nxt, ks: ki_shift};
            end
            if (v0) begin
                sum_q <= sum_nxt;
            end
            if (v1) begin
                drv_mag <= mag_nxt;
                sat     <= clip;
            end
        end
    end
endmodule

// File: tb/tb_pid_gen.sv
// Scoreboard bench for pid_gen with DECIM_W=4: a behavioural model queues each tick's result.
module tb_pid_gen;
    typedef struct {
        int mag;
        int sat;
    } exp_t;

    logic              clk;
    logic              rst;
    logic signed [12:0] error;
    logic              clr_int;
    logic [3:0]        kp;
    logic [3:0]        kd;
    logic [2:0]        ki_shift;
    logic [11:0]       drv_mag;
    logic              drv_vld;
    logic              sat;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t cur;
    int   cyc;
    int   m_hist[3];
    int   m_int;
    int   m_prev;
    bit   seen_first;
    int   last_mag;

    pid_gen #(
        .ERR_W(13), .OUT_W(12), .INT_W(18), .DECIM_W(4), .D_DEPTH(3), .SLEW_MAX(64)
    ) dut (
        .clk(clk), .rst(rst), .error(error), .clr_int(clr_int), .kp(kp), .kd(kd),
        .ki_shift(ki_shift), .drv_mag(drv_mag), .drv_vld(drv_vld), .sat(sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 3; i++) m_hist[i] = 0;
        m_int      = 0;
        m_prev     = 0;
        seen_first = 0;
    endtask

    // Drives one tick's inputs in the tick cycle and queues the expected result.
    task automatic tick(input int e, input int kpv, input int kdv, input int ksv, input int clr);
        int p, dif, d, acc, iv, sum, mag, s;
        @(negedge clk);
        while (cyc % 16 != 15) @(negedge clk);
        error    = e[12:0];
        kp       = kpv[3:0];
        kd       = kdv[3:0];
        ki_shift = ksv[2:0];
        clr_int  = clr[0];
        p   = e * kpv;
        dif = e - m_hist[2];
        if (dif > 255) dif = 255;
        if (dif < -256) dif = -256;
        d = dif * kdv;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = e;
        acc = m_int + e;
        if (acc < 0) acc = 0;
        if (acc > 131071) acc = 131071;
        if (clr != 0) acc = 0;
        m_int = acc;
        iv  = ((m_int / 32) % 4096) >> ksv;
        sum = p + iv + d;
        if (sum < 0) begin
            mag = 0; s = 1;
        end else if (sum > 4095) begin
            mag = 4095; s = 1;
        end else begin
            mag = sum; s = 0;
        end
`ifdef PID_SLEW_EN
        if (mag > m_prev + 64) mag = m_prev + 64;
        else if (mag < m_prev - 64) mag = m_prev - 64;
`endif
        m_prev = mag;
        q.push_back('{mag: mag, sat: s});
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            last_mag = 0;
        end else if (drv_vld) begin
            if (!seen_first) begin
                seen_first = 1;
                chk("first_vld_cycle", cyc, 18);
            end
            if (q.size() == 0) begin
                chk("unexpected_vld", 1, 0);
            end else begin
                cur = q.pop_front();
                chk("drv_mag", int'(drv_mag), cur.mag);
                chk("sat", int'(sat), cur.sat);
                last_mag = cur.mag;
            end
        end else if (cyc % 16 == 8) begin
            chk("hold_mag", int'(drv_mag), last_mag);
        end
    end

    initial begin
        rst = 1'b1; error = '0; clr_int = 1'b0; kp = '0; kd = '0; ki_shift = '0;
        reset_model();
        repeat (5) @(negedge clk);
        chk("rst_drv_mag", int'(drv_mag), 0);
        chk("rst_drv_vld", int'(drv_vld), 0);
        chk("rst_sat", int'(sat), 0);
        rst = 1'b0;

        // Proportional only
        tick(100, 1, 0, 0, 1);
        tick(-5, 1, 0, 0, 1);
        tick(4095, 15, 0, 0, 1);

        // Integrator ramp, shift, upper clamp, lower clamp
        for (int i = 0; i < 40; i++) tick(32, 0, 0, (i == 39) ? 2 : 0, 0);
        for (int i = 0; i < 35; i++) tick(4095, 0, 0, 0, 0);
        for (int i = 0; i < 35; i++) tick(-4096, 0, 0, 0, 0);

        // Derivative steps up and down
        for (int i = 0; i < 3; i++) tick(0, 0, 2, 0, 1);
        for (int i = 0; i < 5; i++) tick(300, 0, 2, 0, 1);
        for (int i = 0; i < 2; i++) tick(0, 0, 2, 0, 1);

        // clr_int on the tick itself
        for (int i = 0; i < 8; i++) tick(400, 0, 0, 0, 0);
        tick(50, 1, 0, 0, 1);
        tick(0, 0, 0, 0, 0);

        // Reset in T+1 drops the in-flight update
        tick(200, 1, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        if (q.size() != 0) void'(q.pop_back());
        repeat (4) @(negedge clk);
        chk("rst_mid_drv_vld", int'(drv_vld), 0);
        chk("rst_mid_drv_mag", int'(drv_mag), 0);
        reset_model();
        rst = 1'b0;
        tick(7, 1, 0, 0, 0);

        // Large proportional step (slewed when the limiter is built in)
        tick(0, 1, 0, 0, 1);
        for (int i = 0; i < 17; i++) tick(1000, 1, 0, 0, 1);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("pending", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
